// File: rtl/fft_bfly_param_if.sv
// ------------------------------------------------------------------
// fft_bfly_param_if : serial word bus for the fft_bfly_param butterfly
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface fft_bfly_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] inp;
  logic             readyin;
  logic             inverse;
  logic             keep_tw;
  logic [WIDTH-1:0] out;
  logic             readyout;
  logic             busy;
  logic             ovf;

  modport master (
    output inp, readyin, inverse, keep_tw,
    input  out, readyout, busy, ovf
  );

  modport slave (
    input  inp, readyin, inverse, keep_tw,
    output out, readyout, busy, ovf
  );
endinterface

`default_nettype wire

// File: rtl/fft_bfly_param.sv
// ------------------------------------------------------------------
// fft_bfly_param : radix-2 DIT butterfly, serial word bus, saturating
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module fft_bfly_param #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6,
  parameter int SCALE = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fft_bfly_param_if.slave bus
);

  localparam int IW = 2*WIDTH + 2;
  localparam logic signed [IW-1:0] MAXV = (IW'(1) <<< (WIDTH-1)) - IW'(1);
  localparam logic signed [IW-1:0] MINV = -MAXV - IW'(1);

  typedef enum logic [3:0] {
    LD_WR = 4'd0,
    LD_WI = 4'd1,
    LD_AR = 4'd2,
    LD_AI = 4'd3,
    LD_BR = 4'd4,
    LD_BI = 4'd5,
    CALC1 = 4'd6,
    CALC2 = 4'd7,
    OUT   = 4'd8
  } state_t;

  state_t state;
  state_t state_nx;

  logic                    readyin_q;
  logic                    strobe;
  logic signed [WIDTH-1:0] wr, wi, ar, ai, br, bi;
  logic signed [WIDTH-1:0] x0r, x0i, x1r, x1i;
  logic        [WIDTH-1:0] out_q;
  logic        [WIDTH-1:0] out_sel;
  logic                    inv;
  logic                    ovf_q;
  logic        [1:0]       idx;
  logic signed [IW-1:0]    pr, pi;
  logic signed [IW-1:0]    wi_eff, prod_re, prod_im;
  logic signed [IW-1:0]    sum [4];
  logic signed [IW-1:0]    scaled;
  logic [3:0][WIDTH-1:0]   satv;
  logic [3:0]              clip;

  function automatic logic signed [IW-1:0] sx(input logic signed [WIDTH-1:0] v);
    sx = IW'(v);
  endfunction

  assign strobe = bus.readyin & ~readyin_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LD_WR;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LD_WR:   if (strobe) state_nx = bus.keep_tw ? LD_AI : LD_WI;
      LD_WI:   if (strobe) state_nx = LD_AR;
      LD_AR:   if (strobe) state_nx = LD_AI;
      LD_AI:   if (strobe) state_nx = LD_BR;
      LD_BR:   if (strobe) state_nx = LD_BI;
      LD_BI:   if (strobe) state_nx = CALC1;
      CALC1:   state_nx = CALC2;
      CALC2:   state_nx = OUT;
      OUT:     if (strobe && idx == 2'd3) state_nx = LD_WR;
      default: state_nx = LD_WR;
    endcase
  end

  // Internal width 2*WIDTH+2 holds (-2^(W-1))^2 sums and the negated twiddle without wrap.
  always_comb begin
    wi_eff  = inv ? -sx(wi) : sx(wi);
    prod_re = sx(wr) * sx(br) - wi_eff * sx(bi);
    prod_im = sx(wr) * sx(bi) + wi_eff * sx(br);
  end

  always_comb begin
    sum[0] = sx(ar) + pr;
    sum[1] = sx(ai) + pi;
    sum[2] = sx(ar) - pr;
    sum[3] = sx(ai) - pi;
    satv   = '0;
    clip   = '0;
    scaled = '0;
    for (int k = 0; k < 4; k++) begin
      scaled = (SCALE != 0) ? (sum[k] >>> 1) : sum[k];
      if (scaled > MAXV) begin
        satv[k] = MAXV[WIDTH-1:0];
        clip[k] = 1'b1;
      end else if (scaled < MINV) begin
        satv[k] = MINV[WIDTH-1:0];
        clip[k] = 1'b1;
      end else begin
        satv[k] = scaled[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    out_sel = x0r;
    case (idx)
      2'd0:    out_sel = x0r;
      2'd1:    out_sel = x0i;
      2'd2:    out_sel = x1r;
      default: out_sel = x1i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readyin_q <= 1'b0;
      wr <= '0; wi <= '0; ar <= '0; ai <= '0; br <= '0; bi <= '0;
      x0r <= '0; x0i <= '0; x1r <= '0; x1i <= '0;
      pr <= '0; pi <= '0;
      inv <= 1'b0;
      ovf_q <= 1'b0;
      idx <= '0;
      out_q <= '0;
    end else begin
      readyin_q <= bus.readyin;
      case (state)
        LD_WR: if (strobe) begin
          ovf_q <= 1'b0;
          if (bus.keep_tw) ar <= bus.inp;
          else             wr <= bus.inp;
        end
        LD_WI: if (strobe) wi <= bus.inp;
        LD_AR: if (strobe) ar <= bus.inp;
        LD_AI: if (strobe) ai <= bus.inp;
        LD_BR: if (strobe) br <= bus.inp;
        LD_BI: if (strobe) begin
          bi  <= bus.inp;
          inv <= bus.inverse;
        end
        CALC1: begin
          pr <= prod_re >>> FRAC;
          pi <= prod_im >>> FRAC;
        end
        CALC2: begin
          x0r <= satv[0];
          x0i <= satv[1];
          x1r <= satv[2];
          x1i <= satv[3];
          if (|clip) ovf_q <= 1'b1;
        end
        OUT: if (strobe) begin
          out_q <= out_sel;
          idx   <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out      = out_q;
  assign bus.readyout = (state == OUT);
  assign bus.busy     = (state == CALC1) || (state == CALC2);
  assign bus.ovf      = ovf_q;

endmodule

`default_nettype wire

// File: doc/fft_bfly_param.md
Name: fft_bfly_param

Overview:
Parametrised radix-2 decimation-in-time butterfly with a single serial byte-style bus. Twiddle W and inputs A and B are complex values, loaded one word per `readyin` strobe. The block computes X0 = A + W·B and X1 = A − W·B, then returns the four result words on later strobes. It is the successor to the fixed 8-bit `fft` block, adding:
- width and twiddle Q-format generics
- optional output scaling
- saturation with a sticky overflow flag
- inverse (conjugate-twiddle) mode
- twiddle reuse across frames

Parameters:
- WIDTH, 8: signed two's-complement width of every data word on `inp`/`out`.
- FRAC, 6: number of fractional bits in twiddle words (1.0 = 2^FRAC).
- SCALE, 0: when 1, both butterfly outputs are arithmetically shifted right by 1 before saturation.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- inp  input  WIDTH  serial data-in word; sampled on the accepted-strobe edge.
- readyin  input  1  strobe request; one event per rising edge of the level.
- inverse  input  1  1 = use conj(W); sampled on entry to CALC1.
- keep_tw  input  1  1 = skip twiddle load for this frame; sampled when state is LD_WR and a strobe is accepted.
- out  output  WIDTH  result word.
- readyout  output  1  high while results are available (state OUT).
- busy  output  1  high in CALC1/CALC2.
- ovf  output  1  sticky saturation flag.

Behaviour:
Reset:
- On `rst`=0, asynchronously: state=LD_WR, word/result index=0, all data registers=0 (including twiddle).
- Outputs: `out`=0, `readyout`=0, `busy`=0, `ovf`=0.
- Reset mid-frame discards the partial frame; the next accepted word is W_re.

Strobe:
- `readyin_q` is registered each cycle; strobe = `readyin` & ~`readyin_q` (reset value of `readyin_q` = 0).
- A level held high for N cycles yields exactly one strobe.

States and load order:
- LD_WR → LD_WI → LD_AR → LD_AI → LD_BR → LD_BI. Each advances on a strobe and captures `inp` on that edge.
- In LD_WR, if `keep_tw`=1 at the strobe, the word is captured as A_re, the state jumps to LD_AI, and the twiddle registers are retained.
- `ovf` clears on the first accepted word of each frame, whether that word is W_re or A_re.

Compute:
- After a strobe in LD_BI → CALC1 (1 cycle) → CALC2 (1 cycle) → OUT.
- Strobes during CALC1/CALC2 are dropped, not queued.
- CALC1 registers:
  - wi' = inverse ? −wi : wi
  - pr = (wr·br − wi'·bi) >>> FRAC
  - pi = (wr·bi + wi'·br) >>> FRAC
  - Full-precision signed internal width 2·WIDTH+2; arithmetic shift (floor toward −∞, no rounding).
- CALC2 forms:
  - X0 = (ar+pr, ai+pi), X1 = (ar−pr, ai−pi)
  - >>>1 if SCALE=1
  - Saturate each component to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Any clipped component sets `ovf` (stays set until next frame start or reset).

Output (state OUT):
- `readyout`=1.
- Each strobe loads `out` with the next word in order X0_re, X0_im, X1_re, X1_im.
- After the 4th strobe, state → LD_WR and `readyout`=0; `out` holds X1_im until the next output strobe of a later frame.
- `out` is registered and changes only on output strobes or reset.

Boundary conditions:
- Extreme values: −2^(WIDTH−1) twiddle × −2^(WIDTH−1) input must not wrap internally.
- `keep_tw` on the first frame after reset uses W=0.
- `inverse` changed during LD states has no effect until CALC1.

Test Plan:
All cases use WIDTH=8, FRAC=6, SCALE=0 unless stated.
1. Basic frame, `readyin` pulses held 2 cycles:
   - Load W=(0x40,0x00), A=(0x02,0x03), B=(0x05,0x06); then 4 strobes.
   - Expect `out` = 0x07, 0x09, 0xFD, 0xFD.
   - `busy` high exactly 2 cycles; `readyout` rises the cycle after CALC2.
2. W=j and inverse:
   - Load W=(0x00,0x40), same A and B → 0xFC, 0x08, 0x08, 0xFE.
   - Repeat with `inverse`=1 → 0x08, 0xFE, 0xFC, 0x08.
3. Saturation and sticky `ovf`:
   - W=(0x40,0), A=(0x64,0), B=(0x64,0) → 0x7F, 0x00, 0x00, 0x00 with `ovf`=1.
   - `ovf` remains 1 through OUT; clears on the next frame's first strobe.
4. Floor shift and `keep_tw`:
   - Frame 1: W=(0x20,0), A=(0,0), B=(0xFD,0) → X0_re=0xFE, X1_re=0x02.
   - Frame 2 with `keep_tw`=1: only 4 words A=(1,1), B=(0x04,0) → 0x03, 0x01, 0xFF, 0x01.
5. Dropped strobes and reset mid-frame:
   - Strobe during CALC1 → no effect; output sequence is unchanged.
   - After 3 loaded words, pulse `rst` low → all outputs 0.
   - A full 6-word frame then yields correct results (case-1 values).
6. SCALE=1 build, case-1 stimulus → 0x03, 0x04, 0xFE, 0xFE.
